// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 65535;
  localparam int TIMEOUT_W   = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: lowest requesting index at or after ptr, wrapping.
module i2c_rr_pick
  import i2c_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int c;
    c      = 0;
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      c = int'(ptr) + off;
      if (c >= NREQ) c = c - NREQ;
      if (!any && req[c]) begin
        any       = 1'b1;
        onehot[c] = 1'b1;
        idx       = PW'(c);
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among NREQ requesters.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | no owner; arbitrate among req starting at ptr
// ST_ISSUE     | m_start (and m_Sr on locked continuation) high this cycle
// ST_WAIT_BUSY | waiting for the master to raise m_busy
// ST_RUN       | waiting for the master to drop m_busy
// ST_DONE      | done pulse; continue locked transfer or release the bus
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr_rw,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        m_address_rw,
  output logic              m_start,
  output logic              m_Sr,
  input  logic              m_busy,
  output logic              m_abort
);

  localparam int PW = ptr_width(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("i2c_master_arbiter: parameter out of range");
  end

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_next;
  logic            lock_q;
  logic            pick_any;
  logic [NREQ-1:0] pick_onehot;
  logic [PW-1:0]   pick_idx;
  logic [7:0]      pick_byte;
  logic [7:0]      win_byte;
  logic            to_hit;

  i2c_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_byte = req_addr_rw[8*pick_idx +: 8];
  assign win_byte  = req_addr_rw[8*win_idx +: 8];
  assign ptr_next  = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LOAD = TIMEOUT_W'(TIMEOUT);
  logic [TIMEOUT_W-1:0] to_cnt;

  // Down-counter: reaching 1 means TIMEOUT cycles have been spent in WAIT_BUSY/RUN.
  assign to_hit = (to_cnt == TIMEOUT_W'(1)) &&
                  ((state == ST_WAIT_BUSY) || (state == ST_RUN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= TO_LOAD;
    end else if (state == ST_ISSUE) begin
      to_cnt <= TO_LOAD;
    end else if (((state == ST_WAIT_BUSY) || (state == ST_RUN)) && !to_hit) begin
      to_cnt <= to_cnt - TIMEOUT_W'(1);
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      win_idx      <= '0;
      lock_q       <= 1'b0;
      gnt          <= '0;
      done         <= '0;
      err          <= '0;
      m_address_rw <= '0;
      m_start      <= 1'b0;
      m_Sr         <= 1'b0;
      m_abort      <= 1'b0;
    end else begin
      done    <= '0;
      err     <= '0;
      m_start <= 1'b0;
      m_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt          <= pick_onehot;
            win_idx      <= pick_idx;
            m_address_rw <= pick_byte;
            lock_q       <= req_lock[pick_idx];
            m_start      <= 1'b1;
            m_Sr         <= 1'b0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          m_Sr  <= 1'b0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_RUN: begin
          if (to_hit) begin
            // Watchdog abort releases the bus regardless of the lock bit.
            err     <= gnt;
            m_abort <= 1'b1;
            gnt     <= '0;
            ptr     <= ptr_next;
            state   <= ST_IDLE;
          end else if ((state == ST_WAIT_BUSY) && m_busy) begin
            state <= ST_RUN;
          end else if ((state == ST_RUN) && !m_busy) begin
            done  <= gnt;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (lock_q && req[win_idx]) begin
            m_address_rw <= win_byte;
            lock_q       <= req_lock[win_idx];
            m_start      <= 1'b1;
            m_Sr         <= 1'b1;
            state        <= ST_ISSUE;
          end else begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Round-robin arbiter and transaction sequencer that shares the single I2C master controller among NREQ requesters. Each requester presents an address/R-W byte and a request; the arbiter grants one, loads the master, issues a start strobe, tracks the master's busy flag to completion and returns a done pulse. It supports locked back-to-back transfers via repeated START and sits between the client blocks and the I2C master controller.

## Interface
- NREQ, 4: number of requesters (2..8)
- TIMEOUT, 65535: watchdog limit in clk cycles (16-bit)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- req  in  NREQ  per-requester transaction request, level
- req_addr_rw  in  8*NREQ  packed; requester i at [8i+7:8i], 7-bit address + R/W LSB
- req_lock  in  NREQ  keep bus after this transfer (next uses repeated START)
- gnt  out  NREQ  one-hot grant, held for the whole transfer
- done  out  NREQ  one-cycle completion pulse to granted requester
- err  out  NREQ  one-cycle timeout pulse to granted requester
- m_address_rw  out  8  address/R-W byte to master
- m_start  out  1  one-cycle transaction start strobe
- m_Sr  out  1  repeated START qualifier, valid with m_start
- m_busy  in  1  master busy flag
- m_abort  out  1  one-cycle abort strobe to master

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE: if any req, pick winner round-robin starting at ptr; register gnt, m_address_rw, lock bit; -> ISSUE. No req: stay.
- ISSUE: m_start=1 for exactly one cycle; m_Sr=1 if entered from DONE via lock, else 0; -> WAIT_BUSY.
- WAIT_BUSY: wait m_busy=1 -> RUN.
- RUN: wait m_busy=0 -> DONE.
- DONE: done[winner]=1 one cycle. If stored lock=1 and req[winner]=1: reload m_address_rw from that requester, -> ISSUE with m_Sr=1, gnt unchanged. Else gnt=0, ptr=winner+1 (wrap NREQ-1 -> 0), -> IDLE.
- Arbitration: lowest index at or after ptr wins, wrapping; single requester always wins regardless of ptr.
- Requester must hold req and req_addr_rw stable until done/err; dropping req mid-transfer does not abort.
- Requests arriving outside IDLE wait; no preemption.
- Reset (any state): state IDLE, ptr 0; gnt, done, err, m_start, m_Sr, m_abort, m_address_rw all 0.

## Timing
- req high at edge k in IDLE -> gnt, m_address_rw valid after edge k; m_start high cycle k..k+1.
- Minimum idle gap between unlocked transfers: one IDLE cycle after DONE.
- Locked continuation: DONE -> ISSUE, no IDLE cycle; m_start two cycles after busy falls.
- done asserted one cycle after m_busy sampled low.

## Configuration
- I2C_ARB_TIMEOUT_EN defined: 16-bit counter runs in WAIT_BUSY and RUN, cleared on entry to ISSUE; at count==TIMEOUT: m_abort=1 and err[winner]=1 for one cycle, gnt cleared, ptr advanced, -> IDLE, lock ignored.
- Not defined: no counter; err and m_abort tied 0; arbiter waits indefinitely.

## Structure
- Package i2c_pkg: state encodings, default NREQ, TIMEOUT width constant.
- Sub-module i2c_rr_pick: combinational round-robin selector (req, ptr -> one-hot winner, index).

## Test plan
- Single req[2], addr 0xA1, master busy 5 cycles -> gnt=0b0100, m_address_rw=0xA1, one m_start, m_Sr=0, done[2] one cycle after busy falls.
- req=0b1011 all held, ptr 0 -> grant order 0,1,3,0; each exactly one done.
- req[1] with req_lock[1]=1, two bytes 0x50 then 0x51 -> second m_start with m_Sr=1, gnt stays 0b0010, no IDLE cycle.
- Timeout (macro on, TIMEOUT=20), m_busy stuck high -> m_abort and err[i] pulse 20 cycles after RUN/WAIT_BUSY entry, return IDLE.
- Reset asserted in RUN -> all outputs 0 immediately; after release, req[3] granted first (ptr 0, only requester).
